// File: rtl/xdma_clock_pkg.sv
// Shared op codes, FSM encodings and default widths for the XDMA clock controller.
package xdma_clock_pkg;

  localparam int STEP_W_DEF = 32;
  localparam int CNT_W_DEF  = 64;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_RUN   = 2'd1,
    OP_PAUSE = 2'd2,
    OP_STEP  = 2'd3
  } op_e;

  // Encoding 3 is unused and recovers to ST_HALT.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/xdma_clock_ctrl_if.sv
// Host command channel of the clock controller: valid/ready handshake with op and step count.
interface xdma_clock_ctrl_if
  import xdma_clock_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/xdma_cycle_counter.sv
// Free-running wrap-around counter of enabled core clock cycles.
module xdma_cycle_counter
  import xdma_clock_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xdma_clock_ctrl.sv
// Core clock-enable controller: HALT / RUN / STEP(N) driven by host commands, gated by
// output-buffer back-pressure, with a running count of enabled cycles.
module xdma_clock_ctrl
  import xdma_clock_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  xdma_clock_ctrl_if.slave     cmd,
  input  logic                 stall_req,
  output logic                 core_clock_enable,
  output logic [1:0]           state,
  output logic                 step_done,
  output logic [CNT_W-1:0]     enabled_cycles
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              fin_d;
  logic              ready_q;
  logic              acc;
  op_e               op;

  assign cmd.cmd_ready = ready_q;
  assign acc           = cmd.cmd_valid & ready_q;
  assign op            = op_e'(cmd.cmd_op);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_HALT;
      rem_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ready_q <= 1'b1;
    end
  end

  // Step progression first; an accepted command then overrides it.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fin_d   = 1'b0;
    case (state_q)
      ST_HALT, ST_RUN: ;
      ST_STEP: begin
        if (en_q) begin
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = ST_HALT;
            fin_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
        rem_d   = '0;
      end
    endcase
    if (acc) begin
      case (op)
        OP_RUN: begin
          state_d = ST_RUN;
          rem_d   = '0;
          fin_d   = 1'b0;
        end
        OP_PAUSE: begin
          state_d = ST_HALT;
          rem_d   = '0;
          fin_d   = 1'b0;
        end
        OP_STEP: begin
          if (cmd.cmd_arg == '0) begin
            state_d = ST_HALT;
            rem_d   = '0;
            fin_d   = 1'b1;
          end else begin
            state_d = ST_STEP;
            rem_d   = cmd.cmd_arg;
            fin_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    en_d   = ((state_d == ST_RUN) || ((state_d == ST_STEP) && (rem_d != '0))) && !stall_req;
    done_d = fin_d;
  end

  xdma_cycle_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (en_q),
    .cnt_o  (enabled_cycles)
  );

  assign core_clock_enable = en_q;
  assign state             = state_q;
  assign step_done         = done_q;

endmodule

// File: tb/tb_xdma_clock_ctrl.sv
// Directed bench for xdma_clock_ctrl: default-width instance plus an 8-bit counter instance for wrap.
module tb_xdma_clock_ctrl;
  import xdma_clock_pkg::*;

  logic        clock;
  logic        reset;
  logic        v;
  logic [1:0]  op_r;
  logic [31:0] arg_r;
  logic        stall;

  logic        en, done, en8, done8;
  logic [1:0]  st, st8;
  logic [63:0] cnt;
  logic [7:0]  cnt8;

  int checks   = 0;
  int failures = 0;

  xdma_clock_ctrl_if #(.STEP_W(32)) cif ();
  xdma_clock_ctrl_if #(.STEP_W(32)) cif8 ();

  assign cif.cmd_valid  = v;
  assign cif.cmd_op     = op_r;
  assign cif.cmd_arg    = arg_r;
  assign cif8.cmd_valid = v;
  assign cif8.cmd_op    = op_r;
  assign cif8.cmd_arg   = arg_r;

  xdma_clock_ctrl #(.STEP_W(32), .CNT_W(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .cmd               (cif.slave),
    .stall_req         (stall),
    .core_clock_enable (en),
    .state             (st),
    .step_done         (done),
    .enabled_cycles    (cnt)
  );

  xdma_clock_ctrl #(.STEP_W(32), .CNT_W(8)) dut8 (
    .clock             (clock),
    .reset             (reset),
    .cmd               (cif8.slave),
    .stall_req         (stall),
    .core_clock_enable (en8),
    .state             (st8),
    .step_done         (done8),
    .enabled_cycles    (cnt8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a);
    v     = 1'b1;
    op_r  = o;
    arg_r = a;
    tick();
    v     = 1'b0;
    op_r  = 2'd0;
    arg_r = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    v     = 1'b0;
    op_r  = 2'd0;
    arg_r = '0;
    stall = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    v     = 1'b0;
    op_r  = 2'd0;
    arg_r = '0;
    stall = 1'b0;

    // Reset values while reset is held low
    tick();
    tick();
    check_eq("rst_state", 64'(st), 64'd0);
    check_eq("rst_en", 64'(en), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_cnt", cnt, 64'd0);
    check_eq("rst_ready", 64'(cif.cmd_ready), 64'd0);
    reset = 1'b1;
    tick();
    check_eq("ready_after_rst", 64'(cif.cmd_ready), 64'd1);

    // RUN at cycle 0, PAUSE at cycle 10
    issue(2'd1, 32'd0);
    check_eq("run_en_c1", 64'(en), 64'd1);
    check_eq("run_state_c1", 64'(st), 64'd1);
    repeat (9) tick();
    check_eq("run_cnt_c10", cnt, 64'd9);
    issue(2'd2, 32'd0);
    check_eq("pause_en_c11", 64'(en), 64'd0);
    check_eq("pause_state_c11", 64'(st), 64'd0);
    check_eq("pause_cnt_c11", cnt, 64'd10);
    tick();
    check_eq("pause_cnt_hold", cnt, 64'd10);

    // STEP 3 from HALT
    do_reset();
    issue(2'd3, 32'd3);
    check_eq("s3_en_c1", 64'(en), 64'd1);
    check_eq("s3_state_c1", 64'(st), 64'd2);
    tick();
    check_eq("s3_en_c2", 64'(en), 64'd1);
    tick();
    check_eq("s3_en_c3", 64'(en), 64'd1);
    check_eq("s3_done_c3", 64'(done), 64'd0);
    tick();
    check_eq("s3_en_c4", 64'(en), 64'd0);
    check_eq("s3_done_c4", 64'(done), 64'd1);
    check_eq("s3_state_c4", 64'(st), 64'd0);
    check_eq("s3_cnt_c4", cnt, 64'd3);
    tick();
    check_eq("s3_done_c5", 64'(done), 64'd0);

    // STEP 4 with stall in cycles 1-2
    do_reset();
    issue(2'd3, 32'd4);
    stall = 1'b1;
    check_eq("s4_en_c1", 64'(en), 64'd1);
    tick();
    check_eq("s4_en_c2", 64'(en), 64'd0);
    check_eq("s4_state_c2", 64'(st), 64'd2);
    tick();
    stall = 1'b0;
    check_eq("s4_en_c3", 64'(en), 64'd0);
    check_eq("s4_cnt_c3", cnt, 64'd1);
    tick();
    check_eq("s4_en_c4", 64'(en), 64'd1);
    tick();
    check_eq("s4_en_c5", 64'(en), 64'd1);
    tick();
    check_eq("s4_en_c6", 64'(en), 64'd1);
    check_eq("s4_done_c6", 64'(done), 64'd0);
    tick();
    check_eq("s4_en_c7", 64'(en), 64'd0);
    check_eq("s4_done_c7", 64'(done), 64'd1);
    check_eq("s4_cnt_c7", cnt, 64'd4);

    // STEP 0
    do_reset();
    issue(2'd3, 32'd0);
    check_eq("s0_done_c1", 64'(done), 64'd1);
    check_eq("s0_en_c1", 64'(en), 64'd0);
    check_eq("s0_state_c1", 64'(st), 64'd0);
    tick();
    check_eq("s0_done_c2", 64'(done), 64'd0);
    check_eq("s0_cnt_c2", cnt, 64'd0);

    // STEP 5 aborted by PAUSE after 2 enabled cycles
    do_reset();
    issue(2'd3, 32'd5);
    tick();
    issue(2'd2, 32'd0);
    check_eq("s5p_en_c3", 64'(en), 64'd0);
    check_eq("s5p_state_c3", 64'(st), 64'd0);
    check_eq("s5p_done_c3", 64'(done), 64'd0);
    check_eq("s5p_cnt_c3", cnt, 64'd2);
    tick();
    check_eq("s5p_done_c4", 64'(done), 64'd0);

    // STEP 5 abandoned by RUN
    do_reset();
    issue(2'd3, 32'd5);
    issue(2'd1, 32'd0);
    check_eq("s5r_state_c2", 64'(st), 64'd1);
    check_eq("s5r_done_c2", 64'(done), 64'd0);
    repeat (6) tick();
    check_eq("s5r_en_c8", 64'(en), 64'd1);
    check_eq("s5r_cnt_c8", cnt, 64'd7);

    // STEP 5 replaced by STEP 2 in cycle 1
    do_reset();
    issue(2'd3, 32'd5);
    issue(2'd3, 32'd2);
    check_eq("rs_en_c2", 64'(en), 64'd1);
    tick();
    check_eq("rs_en_c3", 64'(en), 64'd1);
    tick();
    check_eq("rs_done_c4", 64'(done), 64'd1);
    check_eq("rs_en_c4", 64'(en), 64'd0);
    check_eq("rs_cnt_c4", cnt, 64'd3);

    // RUN accepted under stall: state changes, enable stays gated
    do_reset();
    stall = 1'b1;
    issue(2'd1, 32'd0);
    check_eq("rstall_state_c1", 64'(st), 64'd1);
    check_eq("rstall_en_c1", 64'(en), 64'd0);
    stall = 1'b0;
    tick();
    check_eq("rstall_en_c2", 64'(en), 64'd1);

    // Reset asserted mid-STEP
    do_reset();
    issue(2'd3, 32'd3);
    reset = 1'b0;
    tick();
    check_eq("midrst_state", 64'(st), 64'd0);
    check_eq("midrst_en", 64'(en), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_cnt", cnt, 64'd0);
    check_eq("midrst_ready", 64'(cif.cmd_ready), 64'd0);
    reset = 1'b1;
    tick();
    check_eq("midrst_done_after", 64'(done), 64'd0);
    tick();
    check_eq("midrst_done_after2", 64'(done), 64'd0);

    // 8-bit counter wrap after 255 enabled RUN cycles
    do_reset();
    issue(2'd1, 32'd0);
    repeat (255) tick();
    check_eq("wrap_cnt8_255", 64'(cnt8), 64'd255);
    tick();
    check_eq("wrap_cnt8_0", 64'(cnt8), 64'd0);
    check_eq("wrap_cnt64_256", cnt, 64'd256);
    check_eq("wrap_en8", 64'(en8), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdma_clock_ctrl.md
XDMA_CLOCK_CTRL -- requirements
Module: xdma_clock_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_W, default 32, meaning the width of the step-count argument.
REQ-002 The block SHALL have parameter CNT_W, default 64, meaning the width of the enabled-cycle counter.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: the host command is valid.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the command is accepted this cycle.
REQ-007 The block SHALL have port cmd_op, input, 2 bits: 0 NOP, 1 RUN, 2 PAUSE, 3 STEP.
REQ-008 The block SHALL have port cmd_arg, input, STEP_W bits: the STEP cycle count N.
REQ-009 The block SHALL have port stall_req, input, 1 bit: back-pressure from the difftest output buffer.
REQ-010 The block SHALL have port core_clock_enable, output, 1 bit, registered: drives the clock-gate enable.
REQ-011 The block SHALL have port state, output, 2 bits: current FSM state.
REQ-012 The block SHALL have port step_done, output, 1 bit: one-cycle pulse when a STEP completes.
REQ-013 The block SHALL have port enabled_cycles, output, CNT_W bits: count of cycles with core_clock_enable=1.

Function
REQ-014 The FSM SHALL have states HALT=0, RUN=1 and STEP=2; encoding 3 is unused and SHALL recover to HALT.
REQ-015 cmd_ready SHALL be 1 in every state when out of reset; a command is accepted when cmd_valid=1 and cmd_ready=1.
REQ-016 An accepted RUN SHALL move the FSM to RUN next cycle from any state; if the FSM was in STEP, the step is abandoned and step_done SHALL stay 0.
REQ-017 An accepted PAUSE SHALL move the FSM to HALT next cycle from any state; an aborted STEP SHALL NOT pulse step_done.
REQ-018 An accepted STEP with N>0 SHALL load remaining=N and move the FSM to STEP, also from RUN or STEP, replacing any count in progress.
REQ-019 An accepted STEP with N=0 SHALL move the FSM to HALT and pulse step_done in the next cycle.
REQ-020 NOP SHALL be accepted without effect.
REQ-021 core_clock_enable SHALL be 1 in cycle t+1 iff the state in t+1 is RUN, or is STEP with remaining>0, and stall_req=0 in cycle t.
REQ-022 In STEP, remaining SHALL decrement in every cycle with core_clock_enable=1.
REQ-023 When remaining reaches 0, the FSM SHALL enter HALT and pulse step_done in the cycle after the last enabled cycle.
REQ-024 Over a STEP, core_clock_enable SHALL be high for exactly N cycles, regardless of stall gaps.
REQ-025 A stall SHALL only gate the enable: state and remaining SHALL hold while enable=0 because of a stall.
REQ-026 If a command is accepted in the same cycle as stall_req=1, the command SHALL take effect and the enable SHALL stay gated.
REQ-027 enabled_cycles SHALL increment by 1 in every cycle with core_clock_enable=1 and SHALL wrap modulo 2^CNT_W without saturation.
REQ-028 enabled_cycles SHALL NOT be cleared by PAUSE or RUN.

Reset
REQ-029 While reset=0 at a clock edge, the block SHALL set state=HALT, core_clock_enable=0, step_done=0, remaining=0, enabled_cycles=0 and cmd_ready=0.
REQ-030 A reset during STEP SHALL discard the step with no step_done pulse.
REQ-031 The first command SHALL be accepted no earlier than the first edge with reset=1.

Structure
REQ-032 Op codes, state encodings and default widths SHALL live in the shared package xdma_clock_pkg.
REQ-033 The enabled-cycle counter SHALL be a sub-module xdma_cycle_counter (parameter width, increment enable, synchronous active-low clear).
REQ-034 The block SHALL contain no clock division or gating cell itself; core_clock_enable feeds the existing gate unchanged.

Verification
REQ-035 Reset, then RUN at cycle 0 with no stall: enable=1 from cycle 1; after PAUSE at cycle 10, enable=0 from cycle 11 and enabled_cycles=10.
REQ-036 STEP N=3 from HALT with no stall: enable=1 for cycles 1-3, step_done=1 in cycle 4, state=HALT, enabled_cycles=3.
REQ-037 STEP N=4 with stall_req=1 in cycles 1-2: exactly 4 enabled cycles, step_done one cycle after the last one, remaining held during the stall.
REQ-038 STEP N=0: step_done=1 the next cycle and enable never asserts; STEP N=5 aborted by PAUSE after 2 enabled cycles: no step_done, enabled_cycles=2.
REQ-039 CNT_W=8 with enabled_cycles preset via 255 RUN cycles: the next enabled cycle gives 0 (wrap).
REQ-040 reset=0 asserted mid-STEP: all outputs reach their reset values on the next edge and no step_done pulse occurs.
